hazard_stall_ctrl: RTL and testbench

- Hazard and stall controller for the 5-stage MIPS pipeline.
- Produces the active-high hold signals consumed by the PC and IF/ID pipeline registers (hold=1 freezes the register), plus flush signals for IF/ID and ID/EX.
- Detects load-use hazards and taken-branch flushes, and sequences the multi-cycle mult/div unit.
- Keeps a saturating stall-cycle performance counter.

---
 rtl/hazard_stall_ctrl_if.sv | 36 +++
 rtl/hazard_stall_ctrl.sv | 94 +++++++++
 tb/tb_hazard_stall_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/hazard_stall_ctrl_if.sv
// Signal bundle between the MIPS pipeline datapath and the hazard/stall controller.
// master: pipeline side. It drives the ID/EX hazard fields and consumes hold/flush/md controls.
// slave : controller side. It consumes the hazard fields and drives the controls and the stall counter.
interface hazard_stall_ctrl_if;
    // hazard fields observed in ID and EX
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rt;
    logic        id_is_muldiv;
    logic        id_reads_hilo;
    logic        ex_mem_read;
    logic [4:0]  ex_rt;
    logic        branch_taken_ex;
    // pipeline control returned by the controller
    logic        pc_hold;
    logic        ifid_hold;
    logic        ifid_flush;
    logic        idex_flush;
    logic        md_start;
    logic        md_busy;
    logic [31:0] stall_count;

    modport master (
        output id_rs, id_rt, id_uses_rt, id_is_muldiv, id_reads_hilo,
               ex_mem_read, ex_rt, branch_taken_ex,
        input  pc_hold, ifid_hold, ifid_flush, idex_flush,
               md_start, md_busy, stall_count
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, id_is_muldiv, id_reads_hilo,
               ex_mem_read, ex_rt, branch_taken_ex,
        output pc_hold, ifid_hold, ifid_flush, idex_flush,
               md_start, md_busy, stall_count
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller for the 5-stage MIPS pipeline. It handles load-use stalls, taken-branch flushes,
// mult/div sequencing and HI/LO hazards, and keeps a saturating stall-cycle counter.
// Ports: clk, reset (async, active-high), bus (slave side of hazard_stall_ctrl_if).
// Latency: all controls are combinational from the inputs and the current state. md_busy covers MD_LATENCY cycles after md_start.
module hazard_stall_ctrl #(
    parameter int MD_LATENCY = 32,
    parameter int CNT_W      = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    hazard_stall_ctrl_if.slave   bus
);
    typedef enum logic {IDLE = 1'b0, MD_RUN = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        stall_cnt_q;

    logic lu;
    logic hilo_hz;

    // Register 0 never carries a loaded value, so it cannot create a load-use hazard.
    assign lu = bus.ex_mem_read && (bus.ex_rt != 5'd0) &&
                ((bus.ex_rt == bus.id_rs) || (bus.id_uses_rt && (bus.ex_rt == bus.id_rt)));

    // While the unit is running, HI/LO readers and a second mult/div must wait in ID.
    assign hilo_hz = (state_q == MD_RUN) && (bus.id_reads_hilo || bus.id_is_muldiv);

    // Priority decode: branch flush, then load-use, then HI/LO hazard, then mult/div issue.
    always_comb begin
        bus.pc_hold    = 1'b0;
        bus.ifid_hold  = 1'b0;
        bus.ifid_flush = 1'b0;
        bus.idex_flush = 1'b0;
        bus.md_start   = 1'b0;
        if (bus.branch_taken_ex) begin
            bus.ifid_flush = 1'b1;
            bus.idex_flush = 1'b1;
        end else if (lu || hilo_hz) begin
            bus.pc_hold    = 1'b1;
            bus.ifid_hold  = 1'b1;
            bus.idex_flush = 1'b1;
        end else begin
            bus.md_start   = (state_q == IDLE) && bus.id_is_muldiv;
        end
    end

    // Next-state logic. A taken branch does not cancel a run because the mult/div has already left ID.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.md_start) begin
                    state_d = MD_RUN;
                    cnt_d   = CNT_W'(MD_LATENCY - 1);
                end
            end
            MD_RUN: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Stall-cycle counter. It saturates instead of wrapping, so a long run never reads back as a small count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (bus.pc_hold && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign bus.md_busy     = (state_q == MD_RUN);
    assign bus.stall_count = stall_cnt_q;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl with MD_LATENCY=4.
// Inputs change on the falling edge and outputs are sampled 1ns later, away from the rising edge.
// ctrl packs {pc_hold, ifid_hold, ifid_flush, idex_flush, md_start, md_busy}.
module tb_hazard_stall_ctrl;
    logic clk;
    logic reset;
    int   total;
    int   bad;
    logic [31:0] exp_cnt;
    logic [5:0]  ctrl;

    hazard_stall_ctrl_if bus();

    hazard_stall_ctrl #(.MD_LATENCY(4), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign ctrl = {bus.pc_hold, bus.ifid_hold, bus.ifid_flush, bus.idex_flush, bus.md_start, bus.md_busy};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion before 100000");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        bus.id_rs = 5'd0; bus.id_rt = 5'd0; bus.id_uses_rt = 1'b0;
        bus.id_is_muldiv = 1'b0; bus.id_reads_hilo = 1'b0;
        bus.ex_mem_read = 1'b0; bus.ex_rt = 5'd0; bus.branch_taken_ex = 1'b0;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        step(); #1;
        total++; if (ctrl !== 6'b000000) begin bad++; $display("FAIL reset_ctrl got=%b exp=%b", ctrl, 6'b000000); end
        total++; if (bus.stall_count !== 32'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", bus.stall_count); end
        step(); reset = 1'b0; exp_cnt = 32'd0;
    endtask

    task automatic test_load_use();
        step(); bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd8; bus.id_rs = 5'd8; #1;
        total++; if (ctrl !== 6'b110100) begin bad++; $display("FAIL lu_rs got=%b exp=%b", ctrl, 6'b110100); end
        total++; if (bus.stall_count !== 32'd0) begin bad++; $display("FAIL lu_cnt0 got=%0d exp=0", bus.stall_count); end
        step(); exp_cnt++; clear_inputs(); #1;
        total++; if (ctrl !== 6'b000000) begin bad++; $display("FAIL lu_release got=%b exp=%b", ctrl, 6'b000000); end
        total++; if (bus.stall_count !== 32'd1) begin bad++; $display("FAIL lu_cnt1 got=%0d exp=1", bus.stall_count); end
        step(); bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd8; bus.id_rs = 5'd3; bus.id_rt = 5'd8; bus.id_uses_rt = 1'b0; #1;
        total++; if (ctrl !== 6'b000000) begin bad++; $display("FAIL lu_rt_unused got=%b exp=%b", ctrl, 6'b000000); end
        step(); bus.id_uses_rt = 1'b1; #1;
        total++; if (ctrl !== 6'b110100) begin bad++; $display("FAIL lu_rt_used got=%b exp=%b", ctrl, 6'b110100); end
        step(); exp_cnt++; bus.ex_rt = 5'd0; bus.id_rs = 5'd0; bus.id_rt = 5'd0; #1;
        total++; if (ctrl !== 6'b000000) begin bad++; $display("FAIL lu_r0 got=%b exp=%b", ctrl, 6'b000000); end
        total++; if (bus.stall_count !== exp_cnt) begin bad++; $display("FAIL lu_cnt2 got=%0d exp=%0d", bus.stall_count, exp_cnt); end
        step(); clear_inputs();
    endtask

    task automatic test_muldiv_hilo();
        step(); bus.id_is_muldiv = 1'b1; #1;
        total++; if (ctrl !== 6'b000010) begin bad++; $display("FAIL md_start got=%b exp=%b", ctrl, 6'b000010); end
        step(); bus.id_is_muldiv = 1'b0; bus.id_reads_hilo = 1'b1; #1;
        total++; if (ctrl !== 6'b110101) begin bad++; $display("FAIL hilo_t1 got=%b exp=%b", ctrl, 6'b110101); end
        for (int i = 2; i <= 4; i++) begin
            step(); exp_cnt++; #1;
            total++; if (ctrl !== 6'b110101) begin bad++; $display("FAIL hilo_t%0d got=%b exp=%b", i, ctrl, 6'b110101); end
        end
        step(); exp_cnt++; #1;
        total++; if (ctrl !== 6'b000000) begin bad++; $display("FAIL hilo_release got=%b exp=%b", ctrl, 6'b000000); end
        total++; if (bus.stall_count !== exp_cnt) begin bad++; $display("FAIL hilo_cnt got=%0d exp=%0d", bus.stall_count, exp_cnt); end
        step(); clear_inputs();
    endtask

    task automatic test_back_to_back();
        step(); bus.id_is_muldiv = 1'b1; #1;
        total++; if (ctrl !== 6'b000010) begin bad++; $display("FAIL b2b_start got=%b exp=%b", ctrl, 6'b000010); end
        for (int i = 1; i <= 4; i++) begin
            step(); if (i > 1) exp_cnt++; #1;
            total++; if (ctrl !== 6'b110101) begin bad++; $display("FAIL b2b_wait%0d got=%b exp=%b", i, ctrl, 6'b110101); end
        end
        step(); exp_cnt++; #1;
        total++; if (ctrl !== 6'b000010) begin bad++; $display("FAIL b2b_reissue got=%b exp=%b", ctrl, 6'b000010); end
        for (int i = 1; i <= 4; i++) begin
            step(); clear_inputs(); #1;
            total++; if (ctrl !== 6'b000001) begin bad++; $display("FAIL b2b_busy%0d got=%b exp=%b", i, ctrl, 6'b000001); end
        end
        step(); #1;
        total++; if (ctrl !== 6'b000000) begin bad++; $display("FAIL b2b_idle got=%b exp=%b", ctrl, 6'b000000); end
        total++; if (bus.stall_count !== exp_cnt) begin bad++; $display("FAIL b2b_cnt got=%0d exp=%0d", bus.stall_count, exp_cnt); end
    endtask

    task automatic test_simultaneous();
        step(); bus.branch_taken_ex = 1'b1; bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd8; bus.id_rs = 5'd8; bus.id_is_muldiv = 1'b1; #1;
        total++; if (ctrl !== 6'b001100) begin bad++; $display("FAIL br_prio got=%b exp=%b", ctrl, 6'b001100); end
        step(); clear_inputs(); #1;
        total++; if (ctrl !== 6'b000000) begin bad++; $display("FAIL br_no_start got=%b exp=%b", ctrl, 6'b000000); end
        step(); bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd8; bus.id_rs = 5'd8; bus.id_is_muldiv = 1'b1; #1;
        total++; if (ctrl !== 6'b110100) begin bad++; $display("FAIL lu_over_md got=%b exp=%b", ctrl, 6'b110100); end
        step(); exp_cnt++; bus.ex_mem_read = 1'b0; #1;
        total++; if (ctrl !== 6'b000010) begin bad++; $display("FAIL md_after_lu got=%b exp=%b", ctrl, 6'b000010); end
        step(); clear_inputs(); bus.branch_taken_ex = 1'b1; #1;
        total++; if (ctrl !== 6'b001101) begin bad++; $display("FAIL br_in_run got=%b exp=%b", ctrl, 6'b001101); end
        for (int i = 2; i <= 4; i++) begin
            step(); bus.branch_taken_ex = 1'b0; #1;
            total++; if (ctrl !== 6'b000001) begin bad++; $display("FAIL run_survives%0d got=%b exp=%b", i, ctrl, 6'b000001); end
        end
        step(); #1;
        total++; if (ctrl !== 6'b000000) begin bad++; $display("FAIL sim_idle got=%b exp=%b", ctrl, 6'b000000); end
    endtask

    task automatic test_reset_midrun();
        step(); bus.id_is_muldiv = 1'b1; #1;
        total++; if (ctrl !== 6'b000010) begin bad++; $display("FAIL rst_run_start got=%b exp=%b", ctrl, 6'b000010); end
        step(); bus.id_is_muldiv = 1'b0; #1;
        step(); reset = 1'b1; #1; exp_cnt = 32'd0;
        total++; if (ctrl !== 6'b000000) begin bad++; $display("FAIL rst_busy got=%b exp=%b", ctrl, 6'b000000); end
        total++; if (bus.stall_count !== 32'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", bus.stall_count); end
        step(); reset = 1'b0; bus.id_is_muldiv = 1'b1; #1;
        total++; if (ctrl !== 6'b000010) begin bad++; $display("FAIL md_after_rst got=%b exp=%b", ctrl, 6'b000010); end
        for (int i = 1; i <= 4; i++) begin
            step(); bus.id_is_muldiv = 1'b0; #1;
            total++; if (ctrl !== 6'b000001) begin bad++; $display("FAIL rst_rerun%0d got=%b exp=%b", i, ctrl, 6'b000001); end
        end
        step(); #1;
        total++; if (ctrl !== 6'b000000) begin bad++; $display("FAIL rst_rerun_idle got=%b exp=%b", ctrl, 6'b000000); end
    endtask

    task automatic test_saturation();
        step();
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        #1 release dut.stall_cnt_q;
        bus.ex_mem_read = 1'b1; bus.ex_rt = 5'd9; bus.id_rs = 5'd9; #1;
        total++; if (bus.stall_count !== 32'hFFFF_FFFE) begin bad++; $display("FAIL sat_preload got=%h exp=%h", bus.stall_count, 32'hFFFF_FFFE); end
        step(); #1;
        total++; if (bus.stall_count !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sat_reach got=%h exp=%h", bus.stall_count, 32'hFFFF_FFFF); end
        step(); #1;
        total++; if (bus.stall_count !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sat_hold got=%h exp=%h", bus.stall_count, 32'hFFFF_FFFF); end
        step(); clear_inputs(); #1;
        total++; if (bus.stall_count !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sat_keep got=%h exp=%h", bus.stall_count, 32'hFFFF_FFFF); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        exp_cnt = 32'd0;
        test_reset();
        test_load_use();
        test_muldiv_hilo();
        test_back_to_back();
        test_simultaneous();
        test_reset_midrun();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
